// File: rtl/chacha_aead_sequencer_pkg.sv
// rtl/chacha_aead_sequencer_pkg.sv - core register map, control codes and sequencer state encoding
// Purpose: shared definitions for the ChaCha AEAD core sequencer.
// Ports: none (package).
package chacha_aead_sequencer_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_KEY    = 8'h10;
    localparam logic [7:0] ADDR_NONCE  = 8'h20;
    localparam logic [7:0] ADDR_DATA   = 8'h30;
    localparam logic [7:0] ADDR_TAG    = 8'h40;

    localparam logic [31:0] CTRL_INIT = 32'd1;
    localparam logic [31:0] CTRL_NEXT = 32'd2;
    localparam logic [31:0] CTRL_DONE = 32'd4;

    localparam int STATUS_VALID_BIT = 1;
    localparam int STATUS_TAG_BIT   = 2;

    typedef enum logic [3:0] {
        S_IDLE, S_WKEY, S_WNONCE, S_WAIT_IN, S_WDATA, S_INIT, S_NEXT,
        S_POLL_V, S_RD_DATA, S_POLL_T, S_RD_TAG, S_DONE_W, S_OUTPUT, S_ERR
    } state_e;

endpackage

// File: rtl/chacha_aead_sequencer.sv
// rtl/chacha_aead_sequencer.sv - drives a ChaCha AEAD core over its register bus, one block per handshake
// Purpose: loads key/nonce once per message, then for every input block writes the
//   data, kicks INIT/NEXT, polls for VALID, reads the result, polls for TAG, reads
//   the tag, acknowledges with DONE and presents the block on the output handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, key, nonce        message start pulse and its key/nonce (latched on start)
//   in_valid/in_ready,
//   in_data/in_last          input block handshake
//   out_valid/out_ready,
//   out_data/out_tag/out_last result handshake
//   busy, error              message in progress, sticky poll timeout
//   cs, we, address,
//   write_data, read_data    core register bus
module chacha_aead_sequencer
    import chacha_aead_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 50000,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [255:0]      key,
    input  logic [95:0]       nonce,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [511:0]      in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [511:0]      out_data,
    output logic [127:0]      out_tag,
    output logic              out_last,
    output logic              busy,
    output logic              error,
    output logic              cs,
    output logic              we,
    output logic [ADDR_W-1:0] address,
    output logic [511:0]      write_data,
    input  logic [511:0]      read_data
);

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_e            state_q, state_d;
    logic              ph_q, ph_d;          // 0: strobe cycle, 1: gap cycle (read data sampled)
    logic [2:0]        idx_q, idx_d;
    logic [15:0]       poll_q, poll_d;
    logic [7:0][31:0]  key_q, key_d;
    logic [3:0][31:0]  nonce_q, nonce_d;
    logic [511:0]      blk_q, blk_d;
    logic              last_q, last_d;
    logic [511:0]      out_data_q, out_data_d;
    logic [127:0]      out_tag_q, out_tag_d;

    logic              acc, acc_we;
    logic [7:0]        acc_addr;
    logic [511:0]      acc_wd;
    logic [15:0]       poll_inc;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        idx_d      = idx_q;
        poll_d     = poll_q;
        key_d      = key_q;
        nonce_d    = nonce_q;
        blk_d      = blk_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        acc        = 1'b0;
        acc_we     = 1'b0;
        acc_addr   = '0;
        acc_wd     = '0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        cs         = 1'b0;
        we         = 1'b0;
        address    = '0;
        write_data = '0;
        poll_inc   = poll_q + 16'd1;

        // Every access state leaves only from its gap cycle, so ph_q is 0 on entry.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key;
                    nonce_d = {32'd0, nonce};
                    idx_d   = 3'd0;
                    state_d = S_WKEY;
                end
            end
            S_WKEY: begin
                acc      = 1'b1;
                acc_we   = 1'b1;
                acc_addr = ADDR_KEY | {5'd0, idx_q};
                acc_wd   = {480'd0, key_q[idx_q]};
                if (ph_q) begin
                    idx_d = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_WNONCE;
                end
            end
            S_WNONCE: begin
                acc      = 1'b1;
                acc_we   = 1'b1;
                acc_addr = ADDR_NONCE | {5'd0, idx_q};
                acc_wd   = {480'd0, nonce_q[idx_q[1:0]]};
                if (ph_q) begin
                    idx_d = (idx_q == 3'd2) ? 3'd0 : idx_q + 3'd1;
                    if (idx_q == 3'd2) state_d = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    blk_d   = in_data;
                    last_d  = in_last;
                    state_d = S_WDATA;
                end
            end
            S_WDATA: begin
                acc = 1'b1; acc_we = 1'b1; acc_addr = ADDR_DATA; acc_wd = blk_q;
                if (ph_q) state_d = S_INIT;
            end
            S_INIT: begin
                acc = 1'b1; acc_we = 1'b1; acc_addr = ADDR_CTRL; acc_wd = {480'd0, CTRL_INIT};
                if (ph_q) state_d = S_NEXT;
            end
            S_NEXT: begin
                acc = 1'b1; acc_we = 1'b1; acc_addr = ADDR_CTRL; acc_wd = {480'd0, CTRL_NEXT};
                if (ph_q) begin
                    poll_d  = '0;
                    state_d = S_POLL_V;
                end
            end
            S_POLL_V: begin
                acc = 1'b1; acc_addr = ADDR_STATUS;
                if (ph_q) begin
                    poll_d = poll_inc;
                    if (read_data[STATUS_VALID_BIT]) state_d = S_RD_DATA;
                    else if (poll_inc == TIMEOUT_W) state_d = S_ERR;
                end
            end
            S_RD_DATA: begin
                acc = 1'b1; acc_addr = ADDR_DATA;
                if (ph_q) begin
                    out_data_d = read_data;
                    poll_d     = '0;
                    state_d    = S_POLL_T;
                end
            end
            S_POLL_T: begin
                acc = 1'b1; acc_addr = ADDR_STATUS;
                if (ph_q) begin
                    poll_d = poll_inc;
                    if (read_data[STATUS_TAG_BIT]) state_d = S_RD_TAG;
                    else if (poll_inc == TIMEOUT_W) state_d = S_ERR;
                end
            end
            S_RD_TAG: begin
                acc = 1'b1; acc_addr = ADDR_TAG;
                if (ph_q) begin
                    out_tag_d = read_data[127:0];
                    state_d   = S_DONE_W;
                end
            end
            S_DONE_W: begin
                acc = 1'b1; acc_we = 1'b1; acc_addr = ADDR_CTRL; acc_wd = {480'd0, CTRL_DONE};
                if (ph_q) state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = last_q ? S_IDLE : S_WAIT_IN;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobe on the first cycle of each access, bus fully quiet on the second.
        if (acc) begin
            ph_d = ~ph_q;
            if (!ph_q) begin
                cs         = 1'b1;
                we         = acc_we;
                address    = ADDR_W'(acc_addr);
                write_data = acc_we ? acc_wd : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ph_q       <= 1'b0;
            idx_q      <= '0;
            poll_q     <= '0;
            key_q      <= '0;
            nonce_q    <= '0;
            blk_q      <= '0;
            last_q     <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            idx_q      <= idx_d;
            poll_q     <= poll_d;
            key_q      <= key_d;
            nonce_q    <= nonce_d;
            blk_q      <= blk_d;
            last_q     <= last_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign out_data = out_data_q;
    assign out_tag  = out_tag_q;
    assign out_last = last_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_ERR);
    assign error    = (state_q == S_ERR);

endmodule

// File: tb/tb_chacha_aead_sequencer.sv
// tb/tb_chacha_aead_sequencer.sv - directed self-checking bench for chacha_aead_sequencer
module tb_chacha_aead_sequencer;

    logic         clk = 1'b0;
    logic         rst, start, in_valid, in_ready, in_last;
    logic         out_valid, out_ready, out_last, busy, error, cs, we;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [511:0] in_data, out_data, write_data, read_data;
    logic [127:0] out_tag;
    logic [7:0]   address;

    always #5 clk = ~clk;

    chacha_aead_sequencer #(.TIMEOUT(100), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_last(out_last), .busy(busy), .error(error),
        .cs(cs), .we(we), .address(address), .write_data(write_data),
        .read_data(read_data)
    );

    logic [255:0] key_ref   = {32'h76543210, 32'hfedcba98, 32'h89abcdef, 32'h01234567,
                               32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233};
    logic [95:0]  nonce_ref = 96'h33333333_22222222_11111111;
    logic [511:0] blk_a     = {16{32'hdeadbeef}};
    logic [511:0] blk_b     = {16{32'hcafebabe}};
    logic [511:0] res_a     = {16{32'h84f7e4b5}};   // deadbeef ^ 5a5a5a5a
    logic [511:0] res_b     = {16{32'h90a4e0e4}};   // cafebabe ^ 5a5a5a5a
    logic [127:0] tag_a     = {4{32'h21524110}};    // ~deadbeef
    logic [127:0] tag_b     = {4{32'h35014541}};    // ~cafebabe

    int n_tests = 0;
    int n_fail  = 0;

    // Core model: result = data ^ 5a5a..., tag = ~data[127:0], VALID 20 cycles after NEXT,
    // TAG once the result has been read.
    logic [511:0] core_out;
    logic [127:0] core_tag;
    logic         core_valid, core_tagb;
    int           vcnt;
    bit           never_valid = 1'b0;
    bit           never_tag   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            core_valid <= 1'b0;
            core_tagb  <= 1'b0;
            vcnt       <= 0;
            read_data  <= '0;
        end else begin
            if (vcnt > 0) begin
                vcnt <= vcnt - 1;
                if (vcnt == 1 && !never_valid) core_valid <= 1'b1;
            end
            if (cs && we) begin
                if (address == 8'h30) begin
                    core_out <= write_data ^ {16{32'h5a5a5a5a}};
                    core_tag <= ~write_data[127:0];
                end
                if (address == 8'h08 && write_data[31:0] == 32'd2) vcnt <= 20;
                if (address == 8'h08 && write_data[31:0] == 32'd4) begin
                    core_valid <= 1'b0;
                    core_tagb  <= 1'b0;
                end
            end
            if (cs && !we) begin
                case (address)
                    8'h09: read_data <= {509'd0, core_tagb, core_valid, 1'b0};
                    8'h30: begin
                        read_data <= core_out;
                        if (!never_tag) core_tagb <= 1'b1;
                    end
                    8'h40: read_data <= {384'd0, core_tag};
                    default: read_data <= '0;
                endcase
            end
        end
    end

    // Bus monitor
    int           cyc = 0;
    logic         prev_cs = 1'b0;
    int           viol = 0;
    int           rd30_cnt = 0;
    logic [7:0]   l_addr[$];
    bit           l_we[$];
    logic [511:0] l_wd[$];
    int           l_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prev_cs && (cs || we)) viol <= viol + 1;
        prev_cs <= cs;
        if (cs) begin
            l_addr.push_back(address);
            l_we.push_back(we);
            l_wd.push_back(write_data);
            l_cyc.push_back(cyc);
            if (!we && address == 8'h30) rd30_cnt <= rd30_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input int i, input logic [7:0] a,
                           input bit w, input logic [31:0] d);
        logic [40:0] obs;
        obs = (i < l_addr.size()) ? {l_addr[i], l_we[i], l_wd[i][31:0]} : '1;
        chk(tag, {471'd0, obs}, {471'd0, a, w, d});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cs"}, cs, 0);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_address"}, address, 0);
        chk({tag, "_write_data"}, write_data, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_tag"}, out_tag, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic check_kn(inout int i);
        for (int j = 0; j < 11; j++) begin
            if (j < 8) chk_bus($sformatf("key_wr%0d", j), i, 8'(8'h10 + j), 1'b1, key_ref[j*32 +: 32]);
            else       chk_bus($sformatf("nonce_wr%0d", j - 8), i, 8'(8'h20 + j - 8), 1'b1, nonce_ref[(j-8)*32 +: 32]);
            if (j > 0 && i < l_cyc.size()) chk($sformatf("kn_gap%0d", j), l_cyc[i] - l_cyc[i-1], 2);
            i++;
        end
    endtask

    task automatic check_block(inout int i, input logic [511:0] blk);
        int p;
        chk_bus("data_wr", i, 8'h30, 1'b1, blk[31:0]);
        chk("data_wr_full", (i < l_wd.size()) ? l_wd[i] : '1, blk);
        i++;
        chk_bus("init_wr", i, 8'h08, 1'b1, 32'd1); i++;
        chk_bus("next_wr", i, 8'h08, 1'b1, 32'd2); i++;
        p = 0;
        while (i < l_addr.size() && l_addr[i] == 8'h09) begin p++; i++; end
        chk("poll_v_count", p, 11);
        chk_bus("data_rd", i, 8'h30, 1'b0, 32'd0); i++;
        p = 0;
        while (i < l_addr.size() && l_addr[i] == 8'h09) begin p++; i++; end
        chk("poll_t_count", p, 1);
        chk_bus("tag_rd", i, 8'h40, 1'b0, 32'd0); i++;
        chk_bus("done_wr", i, 8'h08, 1'b1, 32'd4); i++;
    endtask

    task automatic start_msg();
        start = 1'b1; key = key_ref; nonce = nonce_ref;
        @(negedge clk);
        start = 1'b0; key = ~key_ref; nonce = ~nonce_ref;
    endtask

    task automatic send_block(input logic [511:0] d, input logic l);
        int k;
        in_valid = 1'b1; in_data = d; in_last = l;
        k = 0;
        while (!in_ready && k < 200) begin @(negedge clk); k++; end
        chk("in_ready_seen", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        while (!out_valid && k < 400) begin @(negedge clk); k++; end
        chk("out_valid_seen", out_valid, 1);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int base, i, sz, k, p;

    initial begin
        rst = 1'b1; start = 1'b0; key = '0; nonce = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset("reset");

        // Single block message; key/nonce changes and a second start are ignored.
        base = l_addr.size();
        start_msg();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_block(blk_a, 1'b1);
        wait_out();
        chk("m1_out_data", out_data, res_a);
        chk("m1_out_tag", out_tag, tag_a);
        chk("m1_out_last", out_last, 1);
        chk("m1_busy", busy, 1);
        sz = l_addr.size();
        repeat (10) @(negedge clk);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, res_a);
        chk("stall_out_tag", out_tag, tag_a);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_no_bus", l_addr.size(), sz);
        accept();
        chk("m1_busy_after", busy, 0);
        chk("m1_out_valid_after", out_valid, 0);
        i = base;
        check_kn(i);
        check_block(i, blk_a);
        chk("m1_len", l_addr.size(), i);

        // Two block message: key/nonce loaded once, outputs in order.
        base = l_addr.size();
        start_msg();
        send_block(blk_a, 1'b0);
        wait_out();
        chk("m2a_out_data", out_data, res_a);
        chk("m2a_out_last", out_last, 0);
        accept();
        chk("m2_busy_between", busy, 1);
        send_block(blk_b, 1'b1);
        wait_out();
        chk("m2b_out_data", out_data, res_b);
        chk("m2b_out_tag", out_tag, tag_b);
        chk("m2b_out_last", out_last, 1);
        accept();
        chk("m2_busy_after", busy, 0);
        i = base;
        check_kn(i);
        check_block(i, blk_a);
        check_block(i, blk_b);
        chk("m2_len", l_addr.size(), i);

        // Reset while polling for TAG, then a clean message.
        never_tag = 1'b1;
        k = rd30_cnt;
        start_msg();
        send_block(blk_b, 1'b1);
        p = 0;
        while (rd30_cnt == k && p < 300) begin @(negedge clk); p++; end
        chk("poll_t_reached", rd30_cnt, k + 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        never_tag = 1'b0;
        @(negedge clk);
        base = l_addr.size();
        start_msg();
        send_block(blk_b, 1'b1);
        wait_out();
        chk("m3_out_data", out_data, res_b);
        chk("m3_out_tag", out_tag, tag_b);
        accept();
        chk("m3_busy_after", busy, 0);
        i = base;
        check_kn(i);
        check_block(i, blk_b);
        chk("m3_len", l_addr.size(), i);

        // Core never reports VALID: timeout after exactly TIMEOUT status reads.
        never_valid = 1'b1;
        base = l_addr.size();
        start_msg();
        send_block(blk_a, 1'b1);
        k = 0;
        while (!error && k < 400) begin @(negedge clk); k++; end
        chk("to_error", error, 1);
        chk("to_busy", busy, 0);
        p = 0;
        for (int j = base; j < l_addr.size(); j++) if (l_addr[j] == 8'h09) p++;
        chk("to_status_reads", p, 100);
        sz = l_addr.size();
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        chk("to_no_bus", l_addr.size(), sz);
        chk("to_cs", cs, 0);
        chk("to_in_ready", in_ready, 0);
        chk("to_out_valid", out_valid, 0);
        chk("to_error_sticky", error, 1);
        in_valid = 1'b0;

        chk("bus_protocol_viol", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
